// File: rtl/ula_multicycle_ctrl.sv
// Multicycle control unit for the MIPS-subset datapath.
// Moore FSM that drives the ALU operation, the datapath mux selects and the
// write enables. PCEn is the single Mealy output: it folds the ALU zero flag
// into the PC load during a conditional branch.
module ula_multicycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       Z,
  output logic [2:0] ULAcontrol,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       PCEn,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  // Opcode values recognised in DECODE.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes.
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes.
  localparam logic [2:0] ULA_ADD = 3'b000;
  localparam logic [2:0] ULA_SUB = 3'b001;
  localparam logic [2:0] ULA_AND = 3'b010;
  localparam logic [2:0] ULA_OR  = 3'b011;
  localparam logic [2:0] ULA_XOR = 3'b100;
  localparam logic [2:0] ULA_SLT = 3'b101;

  state_t state_q;
  state_t state_d;

  // Raw Moore outputs before reset gating.
  logic [2:0] ula_c;
  logic       src_a_c;
  logic [1:0] src_b_c;
  logic [1:0] pc_src_c;
  logic       iord_c;
  logic       ir_write_c;
  logic       mem_write_c;
  logic       reg_write_c;
  logic       reg_dst_c;
  logic       mem_to_reg_c;
  logic       pc_write_c;
  logic       branch_c;

  // True when funct names an R-type operation this datapath can execute.
  function automatic logic funct_supported(input logic [5:0] f);
    case (f)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLT: funct_supported = 1'b1;
      default:                                       funct_supported = 1'b0;
    endcase
  endfunction

  // Maps an R-type funct to its ALU operation; unknown codes fall back to add.
  function automatic logic [2:0] funct_to_ula(input logic [5:0] f);
    case (f)
      FN_ADD:  funct_to_ula = ULA_ADD;
      FN_SUB:  funct_to_ula = ULA_SUB;
      FN_AND:  funct_to_ula = ULA_AND;
      FN_OR:   funct_to_ula = ULA_OR;
      FN_XOR:  funct_to_ula = ULA_XOR;
      FN_SLT:  funct_to_ula = ULA_SLT;
      default: funct_to_ula = ULA_ADD;
    endcase
  endfunction

  // State register; reset lands in FETCH immediately, without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) state_q <= state_t'(RESET_STATE);
    else        state_q <= state_d;
  end

  // Next-state logic and raw Moore outputs for the current state.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d      = FETCH;
    ula_c        = ULA_ADD;
    src_a_c      = 1'b0;
    src_b_c      = 2'b00;
    pc_src_c     = 2'b00;
    iord_c       = 1'b0;
    ir_write_c   = 1'b0;
    mem_write_c  = 1'b0;
    reg_write_c  = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    pc_write_c   = 1'b0;
    branch_c     = 1'b0;

    case (state_q)
      FETCH: begin
        ir_write_c = 1'b1;
        src_b_c    = 2'b01;
        pc_write_c = 1'b1;
        state_d    = DECODE;
      end
      DECODE: begin
        // Precompute the branch target while the opcode is decoded.
        src_b_c = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = funct_supported(funct) ? EXEC : FETCH;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        src_a_c = 1'b1;
        src_b_c = 2'b10;
        state_d = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord_c  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        mem_to_reg_c = 1'b1;
        reg_write_c  = 1'b1;
        state_d      = FETCH;
      end
      MEMWR: begin
        iord_c      = 1'b1;
        mem_write_c = 1'b1;
        state_d     = FETCH;
      end
      EXEC: begin
        src_a_c = 1'b1;
        ula_c   = funct_to_ula(funct);
        state_d = ALUWB;
      end
      ALUWB: begin
        reg_dst_c   = 1'b1;
        reg_write_c = 1'b1;
        state_d     = FETCH;
      end
      BRANCH: begin
        src_a_c  = 1'b1;
        ula_c    = ULA_SUB;
        pc_src_c = 2'b01;
        branch_c = 1'b1;
        state_d  = FETCH;
      end
      ADDIEX: begin
        src_a_c = 1'b1;
        src_b_c = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        reg_write_c = 1'b1;
        state_d     = FETCH;
      end
      JUMP: begin
        pc_src_c   = 2'b10;
        pc_write_c = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = FETCH;  // encodings 12-15 recover through FETCH
    endcase
  end

  // Output stage: while reset is held nothing is selected or written, even
  // though the state register already shows FETCH.
  always_comb begin
    ULAcontrol = 3'b000;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    PCEn       = 1'b0;
    if (rst_n) begin
      ULAcontrol = ula_c;
      ALUSrcA    = src_a_c;
      ALUSrcB    = src_b_c;
      PCSrc      = pc_src_c;
      IorD       = iord_c;
      IRWrite    = ir_write_c;
      MemWrite   = mem_write_c;
      RegWrite   = reg_write_c;
      RegDst     = reg_dst_c;
      MemtoReg   = mem_to_reg_c;
      // Z only matters while Branch is raised, i.e. in BRANCH.
      PCEn       = pc_write_c | (branch_c & Z);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_ula_multicycle_ctrl.sv
// Directed testbench for ula_multicycle_ctrl. Outputs are sampled on the
// falling clock edge; expected control words are hand-derived per state.
module tb_ula_multicycle_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       Z;

  logic [2:0] ULAcontrol;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic       IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, PCEn;
  logic [3:0] state;

  // Second instance starting in an illegal encoding.
  logic [2:0] i_ula;
  logic       i_srca;
  logic [1:0] i_srcb;
  logic [1:0] i_pcsrc;
  logic       i_iord, i_irw, i_memw, i_regw, i_regdst, i_m2r, i_pcen;
  logic [3:0] i_state;

  int n_cmp  = 0;
  int n_fail = 0;

  // Control word: {ULA[2:0], SrcA, SrcB[1:0], PCSrc[1:0], IorD, IRWrite,
  //                MemWrite, RegWrite, RegDst, MemtoReg, PCEn}
  logic [14:0] ctrl, i_ctrl;
  assign ctrl   = {ULAcontrol, ALUSrcA, ALUSrcB, PCSrc, IorD, IRWrite,
                   MemWrite, RegWrite, RegDst, MemtoReg, PCEn};
  assign i_ctrl = {i_ula, i_srca, i_srcb, i_pcsrc, i_iord, i_irw,
                   i_memw, i_regw, i_regdst, i_m2r, i_pcen};

  localparam logic [14:0] C_ZERO   = 15'b000_0_00_00_0_0_0_0_0_0_0;
  localparam logic [14:0] C_FETCH  = 15'b000_0_01_00_0_1_0_0_0_0_1;
  localparam logic [14:0] C_DECODE = 15'b000_0_11_00_0_0_0_0_0_0_0;
  localparam logic [14:0] C_MEMADR = 15'b000_1_10_00_0_0_0_0_0_0_0;
  localparam logic [14:0] C_MEMRD  = 15'b000_0_00_00_1_0_0_0_0_0_0;
  localparam logic [14:0] C_MEMWB  = 15'b000_0_00_00_0_0_0_1_0_1_0;
  localparam logic [14:0] C_MEMWR  = 15'b000_0_00_00_1_0_1_0_0_0_0;
  localparam logic [14:0] C_EXXOR  = 15'b100_1_00_00_0_0_0_0_0_0_0;
  localparam logic [14:0] C_EXSLT  = 15'b101_1_00_00_0_0_0_0_0_0_0;
  localparam logic [14:0] C_ALUWB  = 15'b000_0_00_00_0_0_0_1_1_0_0;
  localparam logic [14:0] C_BR_Z1  = 15'b001_1_00_01_0_0_0_0_0_0_1;
  localparam logic [14:0] C_BR_Z0  = 15'b001_1_00_01_0_0_0_0_0_0_0;
  localparam logic [14:0] C_ADDIEX = 15'b000_1_10_00_0_0_0_0_0_0_0;
  localparam logic [14:0] C_ADDIWB = 15'b000_0_00_00_0_0_0_1_0_0_0;
  localparam logic [14:0] C_JUMP   = 15'b000_0_00_10_0_0_0_0_0_0_1;

  ula_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .Z(Z),
    .ULAcontrol(ULAcontrol), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSrc(PCSrc), .IorD(IorD), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .PCEn(PCEn), .state(state)
  );

  ula_multicycle_ctrl #(.RESET_STATE(4'd12)) dut_ill (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .Z(Z),
    .ULAcontrol(i_ula), .ALUSrcA(i_srca), .ALUSrcB(i_srcb),
    .PCSrc(i_pcsrc), .IorD(i_iord), .IRWrite(i_irw), .MemWrite(i_memw),
    .RegWrite(i_regw), .RegDst(i_regdst), .MemtoReg(i_m2r),
    .PCEn(i_pcen), .state(i_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %b expected %b", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  // Check state and control word in the current cycle, then move to the next.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [14:0] c);
    check({tag, "/state"}, {12'd0, state}, {12'd0, st});
    check({tag, "/ctrl"}, {1'b0, ctrl}, {1'b0, c});
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    op    = 6'b000000;
    funct = 6'b000000;
    Z     = 1'b0;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst/state", {12'd0, state}, 16'd0);
    check("rst/ctrl", {1'b0, ctrl}, {1'b0, C_ZERO});
    check("rst_ill/state", {12'd0, i_state}, 16'd12);
    check("rst_ill/ctrl", {1'b0, i_ctrl}, {1'b0, C_ZERO});

    // Release: FETCH outputs appear, next edge moves to DECODE.
    rst_n = 1'b1;
    #1;
    check("ill12/ctrl", {1'b0, i_ctrl}, {1'b0, C_ZERO});
    // XOR R-type, with Z held high to show it is ignored outside BRANCH.
    funct = 6'b100110;
    Z     = 1'b1;
    cyc("xor_fetch", 4'd0, C_FETCH);
    check("ill12/recover", {12'd0, i_state}, 16'd0);
    cyc("xor_decode", 4'd1, C_DECODE);
    cyc("xor_exec", 4'd6, C_EXXOR);
    cyc("xor_aluwb", 4'd7, C_ALUWB);

    // slt R-type for a second funct mapping.
    Z     = 1'b0;
    funct = 6'b101010;
    cyc("slt_fetch", 4'd0, C_FETCH);
    cyc("slt_decode", 4'd1, C_DECODE);
    cyc("slt_exec", 4'd6, C_EXSLT);
    cyc("slt_aluwb", 4'd7, C_ALUWB);

    // lw: five cycles, MemtoReg only in MEMWB.
    op = 6'b100011;
    cyc("lw_fetch", 4'd0, C_FETCH);
    cyc("lw_decode", 4'd1, C_DECODE);
    cyc("lw_memadr", 4'd2, C_MEMADR);
    cyc("lw_memrd", 4'd3, C_MEMRD);
    cyc("lw_memwb", 4'd4, C_MEMWB);

    // sw: four cycles, one MemWrite cycle.
    op = 6'b101011;
    cyc("sw_fetch", 4'd0, C_FETCH);
    cyc("sw_decode", 4'd1, C_DECODE);
    cyc("sw_memadr", 4'd2, C_MEMADR);
    cyc("sw_memwr", 4'd5, C_MEMWR);

    // beq taken, then Z dropped inside BRANCH (Mealy path).
    op = 6'b000100;
    cyc("beq1_fetch", 4'd0, C_FETCH);
    cyc("beq1_decode", 4'd1, C_DECODE);
    Z = 1'b1;
    #1;
    check("beq1_br/ctrl_z1", {1'b0, ctrl}, {1'b0, C_BR_Z1});
    Z = 1'b0;
    #1;
    check("beq1_br/ctrl_z0", {1'b0, ctrl}, {1'b0, C_BR_Z0});
    cyc("beq1_branch", 4'd8, C_BR_Z0);

    // beq not taken; Z toggled in FETCH leaves PCEn high.
    Z = 1'b1;
    #1;
    check("beq2_fetch_z1", {1'b0, ctrl}, {1'b0, C_FETCH});
    Z = 1'b0;
    cyc("beq2_fetch", 4'd0, C_FETCH);
    cyc("beq2_decode", 4'd1, C_DECODE);
    cyc("beq2_branch", 4'd8, C_BR_Z0);

    // addi.
    op = 6'b001000;
    cyc("addi_fetch", 4'd0, C_FETCH);
    cyc("addi_decode", 4'd1, C_DECODE);
    cyc("addi_ex", 4'd9, C_ADDIEX);
    cyc("addi_wb", 4'd10, C_ADDIWB);

    // j.
    op = 6'b000010;
    cyc("j_fetch", 4'd0, C_FETCH);
    cyc("j_decode", 4'd1, C_DECODE);
    cyc("j_jump", 4'd11, C_JUMP);

    // Unsupported opcode: NOP in two cycles.
    op = 6'b111111;
    cyc("bad_op_fetch", 4'd0, C_FETCH);
    cyc("bad_op_decode", 4'd1, C_DECODE);

    // R-type with unsupported funct: NOP in two cycles.
    op    = 6'b000000;
    funct = 6'b000111;
    cyc("bad_fn_fetch", 4'd0, C_FETCH);
    cyc("bad_fn_decode", 4'd1, C_DECODE);

    // lw aborted by asynchronous reset during MEMWB.
    op = 6'b100011;
    cyc("lwab_fetch", 4'd0, C_FETCH);
    cyc("lwab_decode", 4'd1, C_DECODE);
    cyc("lwab_memadr", 4'd2, C_MEMADR);
    cyc("lwab_memrd", 4'd3, C_MEMRD);
    check("lwab_memwb/ctrl", {1'b0, ctrl}, {1'b0, C_MEMWB});
    #2;
    rst_n = 1'b0;
    #1;
    check("lwab_rst/state", {12'd0, state}, 16'd0);
    check("lwab_rst/regwrite", {15'd0, RegWrite}, 16'd0);
    check("lwab_rst/ctrl", {1'b0, ctrl}, {1'b0, C_ZERO});
    @(negedge clk);
    check("lwab_hold/state", {12'd0, state}, 16'd0);
    rst_n = 1'b1;
    #1;
    cyc("restart_fetch", 4'd0, C_FETCH);
    cyc("restart_decode", 4'd1, C_DECODE);
    cyc("restart_memadr", 4'd2, C_MEMADR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
